// File: rtl/mux_rr_arbiter_4to1_32b_pkg.sv
// Shared constants for the 4-way requester arbiter and its picker.
// Mode encodings, requester count, index width, one-hot helper.
package mux_rr_arbiter_4to1_32b_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  localparam int   NREQ       = 4;
  localparam int   IDXW       = 2;

  function automatic logic [NREQ-1:0] onehot(
    input logic [IDXW-1:0] i
  );
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux_4to1_32b.sv
// Plain 4-to-1 word multiplexer.
// Ports: in0..in3 data, select index, out chosen word.
module mux_4to1_32b #(
  parameter int size = 32
) (
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  input  logic [size-1:0] in2,
  input  logic [size-1:0] in3,
  input  logic [1:0]      select,
  output logic [size-1:0] out
);

  always_comb begin
    out = in0;
    case (select)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational 4-way picker: round-robin from ptr, or lowest index.
// Ports: req, ptr, mode in; any (some req set), win (index) out.
module rr_pick4
  import mux_rr_arbiter_4to1_32b_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  input  logic            mode,
  output logic            any,
  output logic [IDXW-1:0] win
);

  logic [IDXW-1:0] base;
  logic [IDXW-1:0] idx;

  assign any = |req;

  // Walk offsets high to low so the nearest
  // requester after base is the last one kept.
  always_comb begin
    base = (mode == MODE_FIXED) ? '0 : ptr;
    win  = base;
    idx  = base;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = base + IDXW'(i);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_4to1_32b.sv
// Four valid/ready requesters arbitrated into one registered output slot.
// Ports: CGRA_Clock/CGRA_Reset, in0..3, in_valid/in_ready, mode, out/out_valid/out_ready, select.
module mux_rr_arbiter_4to1_32b
  import mux_rr_arbiter_4to1_32b_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            CGRA_Clock,
  input  logic            CGRA_Reset,
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  input  logic [size-1:0] in2,
  input  logic [size-1:0] in3,
  input  logic [3:0]      in_valid,
  output logic [3:0]      in_ready,
  input  logic            mode,
  output logic [size-1:0] out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      select
);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] win;
  logic            any;
  logic            load_en;
  logic            grant;
  logic [size-1:0] word;

  rr_pick4 u_pick (
    .req  (in_valid),
    .ptr  (ptr),
    .mode (mode),
    .any  (any),
    .win  (win)
  );

  mux_4to1_32b #(.size(size)) u_mux (
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .select (win),
    .out    (word)
  );

  // Slot is free, or its word leaves this cycle.
  assign load_en  = !out_valid || out_ready;
  assign grant    = load_en && CGRA_Reset && any;
  assign in_ready = grant ? onehot(win) : '0;

  always_ff @(posedge CGRA_Clock) begin
    if (!CGRA_Reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      select    <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out       <= word;
      out_valid <= 1'b1;
      select    <= win;
      // Tracked in both modes so a switch to
      // round-robin starts after the last winner.
      ptr       <= win + 2'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter_4to1_32b.sv
// Self-checking bench for the 4-way arbitrated output register.
// Scenario tasks plus a randomized run against a transaction-level model.
module tb_mux_rr_arbiter_4to1_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d[4];
  logic [3:0]  iv = '0;
  logic [3:0]  in_ready;
  logic        mode = 1'b0;
  logic [31:0] out;
  logic        out_valid;
  logic        ordy = 1'b0;
  logic [1:0]  select;

  int checks   = 0;
  int failures = 0;

  // Reference model: held word, its index, occupancy, rr start.
  logic [31:0] m_out;
  logic        m_valid;
  logic [1:0]  m_sel;
  int          m_ptr;

  always #5 clk = ~clk;

  mux_rr_arbiter_4to1_32b dut (
    .CGRA_Clock (clk),
    .CGRA_Reset (rst),
    .in0        (d[0]),
    .in1        (d[1]),
    .in2        (d[2]),
    .in3        (d[3]),
    .in_valid   (iv),
    .in_ready   (in_ready),
    .mode       (mode),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (ordy),
    .select     (select)
  );

  // Winner by the arbitration rule, -1 if nobody requests.
  function automatic int pick();
    int base;
    base = mode ? 0 : m_ptr;
    for (int k = 0; k < 4; k++)
      if (iv[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy();
    int w;
    logic [3:0] r;
    w = pick();
    r = '0;
    if (rst && (!m_valid || ordy) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // One clock: advance the model on the edge, then settle.
  task automatic tick();
    int   w;
    logic ld;
    w  = pick();
    ld = !m_valid || ordy;
    @(posedge clk);
    if (!rst) begin
      m_out = '0; m_valid = 1'b0; m_sel = '0; m_ptr = 0;
    end else if (ld && w >= 0) begin
      m_out = d[w]; m_valid = 1'b1;
      m_sel = w[1:0]; m_ptr = (w + 1) % 4;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; iv = 4'hF; ordy = 1'b1; mode = 1'b0;
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
    end
    tick(); tick();
    checks++;
    if ({out_valid, select, out} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b s=%0d o=%h exp 0/0/0",
               out_valid, select, out);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold_ready got=%b exp=0000", in_ready);
    end
    rst = 1'b1; #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant got=%b exp=0001", in_ready);
    end
    tick();
    checks++;
    if (out !== 32'hA0 || select !== 2'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_xfer got o=%h s=%0d v=%b exp a0/0/1",
               out, select, out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] eo[5];
    logic [1:0]  es[5];
    eo = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b0; tick(); rst = 1'b1;
    iv = 4'hF; ordy = 1'b1; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out !== eo[i] || select !== es[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq[%0d] got o=%h s=%0d v=%b exp o=%h s=%0d v=1",
                 i, out, select, out_valid, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] vs[5];
    logic [1:0] es[5];
    vs = '{4'b1000, 4'b0110, 4'b0110, 4'b1000, 4'b1111};
    es = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    ordy = 1'b1; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv = vs[i];
      tick();
      checks++;
      if (select !== es[i] || select !== m_sel || out !== m_out) begin
        failures++;
        $display("FAIL skip_wrap[%0d] got s=%0d o=%h exp s=%0d o=%h",
                 i, select, out, es[i], m_out);
      end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b1; ordy = 1'b1; iv = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        failures++;
        $display("FAIL fixed_ready[%0d] got=%b exp=0010", i, in_ready);
      end
      tick();
      checks++;
      if (select !== 2'd1 || out !== d[1]) begin
        failures++;
        $display("FAIL fixed_sel[%0d] got s=%0d o=%h exp s=1 o=%h",
                 i, select, out, d[1]);
      end
    end
    iv = 4'b1100;
    tick();
    checks++;
    if (select !== 2'd2 || out !== d[2]) begin
      failures++;
      $display("FAIL fixed_drop got s=%0d o=%h exp s=2 o=%h",
               select, out, d[2]);
    end
    mode = 1'b0;
  endtask

  task automatic test_backpressure();
    ordy = 1'b1; iv = 4'b0001; d[0] = 32'hDEADBEEF;
    tick();
    ordy = 1'b0; iv = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready);
      end
      tick();
      checks++;
      if (out !== 32'hDEADBEEF || select !== 2'd0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got o=%h s=%0d v=%b exp deadbeef/0/1",
                 i, out, select, out_valid);
      end
    end
    ordy = 1'b1; iv = 4'b0100; d[2] = 32'h12345678;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL drain_fill_ready got=%b exp=0100", in_ready);
    end
    tick();
    checks++;
    if (out !== 32'h12345678 || select !== 2'd2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_fill got o=%h s=%0d v=%b exp 12345678/2/1",
               out, select, out_valid);
    end
  endtask

  task automatic test_drain_reset();
    iv = 4'b0000; ordy = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL idle_ready got=%b exp=0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out !== 32'h12345678 || select !== 2'd2) begin
      failures++;
      $display("FAIL drain got v=%b o=%h s=%0d exp 0/12345678/2",
               out_valid, out, select);
    end
    iv = 4'b0010; tick();
    iv = 4'b0000; ordy = 1'b0; tick();
    rst = 1'b0; tick();
    checks++;
    if (out_valid !== 1'b0 || out !== 32'd0 || select !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got v=%b o=%h s=%0d exp 0/0/0",
               out_valid, out, select);
    end
    rst = 1'b1; iv = 4'hF; ordy = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL ptr_after_reset got=%b exp=0001", in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) d[j] = $urandom;
      iv   = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      rst  = ($urandom_range(0, 39) != 0);
      #1;
      checks++;
      if (in_ready !== exp_rdy()) begin
        failures++;
        $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy());
      end
      tick();
      checks++;
      if ({out_valid, select, out} !== {m_valid, m_sel, m_out}) begin
        failures++;
        $display("FAIL rnd_out[%0d] got v=%b s=%0d o=%h exp v=%b s=%0d o=%h",
                 i, out_valid, select, out, m_valid, m_sel, m_out);
      end
    end
  endtask

  initial begin
    m_out = '0; m_valid = 1'b0; m_sel = '0; m_ptr = 0;
    for (int j = 0; j < 4; j++) d[j] = '0;
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_fixed();
    test_backpressure();
    test_drain_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter_4to1_32b.md
Name: mux_rr_arbiter_4to1_32b

Overview:
Arbitrating front end for the 4-to-1 32-bit select mux. It takes four valid/ready requester channels and chooses one per cycle, round-robin or fixed-priority. It drives the mux select and captures the winning word into a one-entry output register with a valid/ready handshake. It sits between four producer FUs/ports and a single shared consumer in the CGRA datapath.

Parameters:
size, 32, data width of every in*/out word

Ports:
CGRA_Clock  input  1  sole clock; all state updates on rising edge
CGRA_Reset  input  1  synchronous, active-low reset (0 = reset, sampled on CGRA_Clock)
in0  input  size  requester 0 data
in1  input  size  requester 1 data
in2  input  size  requester 2 data
in3  input  size  requester 3 data
in_valid  input  4  bit i = requester i has data
in_ready  output  4  bit i = requester i's word is taken this cycle (one-hot or zero)
mode  input  1  0 = round-robin, 1 = fixed priority (in0 highest, in3 lowest)
out  output  size  registered winning word
out_valid  output  1  out holds an untaken word
out_ready  input  1  consumer accepts out this cycle
select  output  2  index of the requester whose word currently sits in out

Behaviour:
- Reset (CGRA_Reset=0 at an edge):
  - out=0, out_valid=0, select=0, rr pointer ptr=0.
  - in_ready=0 combinationally while CGRA_Reset=0.
  - A reset mid-transfer discards the held word; no transfer completes in a reset cycle.
- load_en = !out_valid || out_ready (output slot free or draining this cycle).
- Arbitration (combinational, same cycle):
  - mode=0: search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first with in_valid=1 wins.
  - mode=1: the lowest index with in_valid=1 wins; ptr is ignored.
- in_ready[w] = load_en && CGRA_Reset && any(in_valid); all other bits 0.
  - in_ready may depend combinationally on in_valid. in_valid must not depend on in_ready.
- Transfer (in_valid[w] && in_ready[w]) at an edge:
  - out <= in_w via mux_4to1_32b with select=w.
  - out_valid <= 1, select register <= w.
  - ptr <= (w+1) mod 4. ptr is updated in both modes, so switching modes never leaves a stale pointer.
- No transfer and out_ready=1: out_valid <= 0. out and select hold their last values.
- No transfer and out_ready=0: all state holds. out is stable while out_valid=1 && out_ready=0.
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is one word per cycle; back-to-back transfers are allowed when out_ready=1 continuously.
- Simultaneous drain and fill (out_valid=1, out_ready=1, winner present): the old word leaves, the new word loads, and out_valid stays 1.
- Fairness, mode=0: a requester holding in_valid=1 is granted within 4 transfers.
- Fairness, mode=1: no starvation bound.
- mode changes take effect at the next arbitration decision. There is no pipeline flush and the held word is unaffected.
- Wrap-around: ptr 3 -> 0. A winner w=3 sets ptr=0.
- All in_valid=0: in_ready=0 and ptr holds.

Decomposition:
- Shared package: constants MODE_RR=1'b0 and MODE_FIXED=1'b1, the requester count 4, and the index width 2.
- Sub-module rr_pick4:
  - Purely combinational.
  - Inputs: req[3:0], ptr[1:0], mode.
  - Outputs: any, win[1:0].
  - It is reused by other shared-resource arbiters.
- The data path instantiates the existing mux_4to1_32b with select=win.
- ptr and the output register live in the top module.

Test Plan:
1. Reset: hold CGRA_Reset=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out=0, select=0. Release -> first transfer grants in0 (ptr=0).
2. Round-robin: mode=0, in_valid=1111 held, data in0..3 = 0xA0,0xA1,0xA2,0xA3, out_ready=1 -> out sequence 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles, and select cycles 0,1,2,3,0.
3. Pointer skip/wrap: after in3 wins (ptr=0), set in_valid=0110 -> in1 wins, then in2. Then in_valid=1000 -> in3 wins and ptr wraps to 0.
4. Fixed priority: mode=1, in_valid=1110 held -> in1 granted every cycle and in2/in3 are never granted. Drop in1 -> in2 is granted.
5. Backpressure: out_ready=0 after out=0xDEADBEEF loads -> in_ready=0000 and out/select/out_valid stable for 5 cycles. Raise out_ready with in2 valid -> same-edge drain and fill, out_valid stays 1, out=in2.
6. Drain to empty and mid-run reset: all in_valid=0, out_ready=1 -> out_valid falls after 1 cycle. Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and ptr=0.
